// File: rtl/prng_shift_seq.sv
// Sequencer that seeds a 4-bit universal shift register and runs it as a q3^q0 LFSR,
// streaming one pseudo-random bit per valid/ready handshake.
`timescale 1ns / 1ps

module prng_shift_seq #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       seed,
   input  logic [CNT_W-1:0] nbits,
   input  logic [3:0]       reg_q,
   output logic [1:0]       reg_sel,
   output logic             reg_sl_din,
   output logic             reg_sr_din,
   output logic             rnd_bit,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StRun,
      StDone
   } state_e;

   localparam logic [1:0] SelHold   = 2'b00;
   localparam logic [1:0] SelInvert = 2'b01;
   localparam logic [1:0] SelShl    = 2'b11;

   state_e           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [3:0]       seed_q, seed_d;

   assign reg_sr_din = 1'b0;
   assign rnd_bit    = reg_q[3];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rem_d      = rem_q;
      seed_d     = seed_q;
      reg_sel    = SelHold;
      reg_sl_din = 1'b0;
      rnd_valid  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               seed_d  = seed;
               rem_d   = nbits;
               idx_d   = 2'd0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            busy       = 1'b1;
            reg_sel    = SelShl;
            // ~idx == 3-idx for a 2-bit index: seed MSB shifts in first
            reg_sl_din = seed_q[~idx_q];
            idx_d      = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = StCheck;
         end
         StCheck: begin
            busy = 1'b1;
            // all-zero is the LFSR lockup state; invert escapes to 1111
            if (reg_q == 4'b0000) reg_sel = SelInvert;
            state_d = (rem_q == '0) ? StDone : StRun;
         end
         StRun: begin
            busy      = 1'b1;
            rnd_valid = 1'b1;
            if (rnd_ready) begin
               reg_sel    = SelShl;
               reg_sl_din = reg_q[3] ^ reg_q[0];
               rem_d      = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) state_d = StDone;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 2'd0;
         rem_q   <= '0;
         seed_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         seed_q  <= seed_d;
      end
   end

endmodule

// File: tb/tb_prng_shift_seq.sv
// Directed bench for prng_shift_seq; includes a behavioural model of the 4-bit universal
// shift register so the sequencer drives a closed loop.
`timescale 1ns / 1ps

module tb_prng_shift_seq;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       seed;
   logic [CNT_W-1:0] nbits;
   logic [3:0]       reg_q;
   logic [1:0]       reg_sel;
   logic             reg_sl_din;
   logic             reg_sr_din;
   logic             rnd_bit;
   logic             rnd_valid;
   logic             rnd_ready;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   prng_shift_seq #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed      (seed),
      .nbits     (nbits),
      .reg_q     (reg_q),
      .reg_sel   (reg_sel),
      .reg_sl_din(reg_sl_din),
      .reg_sr_din(reg_sr_din),
      .rnd_bit   (rnd_bit),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .busy      (busy),
      .done      (done)
   );

   // Universal shift register; its rst_n is ~rst so it resets on the same edge.
   always_ff @(posedge clk) begin
      if (rst) reg_q <= 4'b0000;
      else begin
         case (reg_sel)
            2'b01:   reg_q <= ~reg_q;
            2'b10:   reg_q <= {reg_sr_din, reg_q[3:1]};
            2'b11:   reg_q <= {reg_q[2:0], reg_sl_din};
            default: reg_q <= reg_q;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accept start at E0, check LOAD and CHECK; returns in cycle E0+6.
   // glitch raises start during LOAD to confirm it is ignored.
   task automatic start_run(input logic [3:0] s, input logic [CNT_W-1:0] n, input bit glitch);
      seed  = s;
      nbits = n;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("load_sel", 32'(reg_sel), 32'd3);
         chk("load_din", 32'(reg_sl_din), 32'(s[3-i]));
         chk("load_busy", 32'(busy), 32'd1);
         chk("load_valid", 32'(rnd_valid), 32'd0);
         start = (glitch && i == 1);
         tick();
      end
      start = 1'b0;
      chk("check_q", 32'(reg_q), 32'(s));
      chk("check_sel", 32'(reg_sel), (s == 4'b0000) ? 32'd1 : 32'd0);
      chk("check_busy", 32'(busy), 32'd1);
      tick();
   endtask

   // exp_bits lists the expected bits first-at-MSB.
   task automatic run_full(input logic [3:0] s, input logic [CNT_W-1:0] n,
                           input logic [14:0] exp_bits, input logic [3:0] fin, input bit glitch);
      rnd_ready = 1'b1;
      start_run(s, n, glitch);
      for (int i = 0; i < int'(n); i++) begin
         chk("run_valid", 32'(rnd_valid), 32'd1);
         chk("run_bit", 32'(rnd_bit), 32'(exp_bits[14-i]));
         chk("run_sel", 32'(reg_sel), 32'd3);
         chk("run_done", 32'(done), 32'd0);
         tick();
      end
      chk("end_done", 32'(done), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_valid", 32'(rnd_valid), 32'd0);
      chk("end_sel", 32'(reg_sel), 32'd0);
      chk("end_q", 32'(reg_q), 32'(fin));
      tick();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [6:0] pat;
      logic [3:0] prev_q;
      int         k;

      rst       = 1'b1;
      start     = 1'b0;
      seed      = 4'd0;
      nbits     = '0;
      rnd_ready = 1'b0;
      tick();
      tick();
      chk("rst_sel", 32'(reg_sel), 32'd0);
      chk("rst_sl", 32'(reg_sl_din), 32'd0);
      chk("rst_sr", 32'(reg_sr_din), 32'd0);
      chk("rst_valid", 32'(rnd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bit", 32'(rnd_bit), 32'd0);
      rst = 1'b0;
      tick();

      // Seed 0001, 4 bits; done in E0+10.
      run_full(4'b0001, 8'd4, 15'b0001_0000000_0000, 4'b1110, 1'b0);
      // Start in the cycle right after done; all-zero seed escapes via invert.
      run_full(4'b0000, 8'd3, 15'b111_000000000000, 4'b1010, 1'b0);
      // Full period: q[3] of each visited state, returning to the seed.
      run_full(4'b1001, 8'd15, 15'b100100011110101, 4'b1001, 1'b0);

      // Ready pattern 1,0,0,1,0,1,1 gives the same bits as the first run.
      rnd_ready = 1'b1;
      start_run(4'b0001, 8'd4, 1'b0);
      pat = 7'b1001011;
      k   = 0;
      for (int i = 0; i < 7; i++) begin
         rnd_ready = pat[6-i];
         #1;
         chk("tog_valid", 32'(rnd_valid), 32'd1);
         prev_q = reg_q;
         if (pat[6-i]) begin
            chk("tog_bit", 32'(rnd_bit), 32'(k == 3));
            chk("tog_sel_hi", 32'(reg_sel), 32'd3);
            k++;
         end else begin
            chk("tog_sel_lo", 32'(reg_sel), 32'd0);
            chk("tog_sl_lo", 32'(reg_sl_din), 32'd0);
         end
         tick();
         if (!pat[6-i]) chk("tog_frozen", 32'(reg_q), 32'(prev_q));
      end
      chk("tog_done", 32'(done), 32'd1);
      chk("tog_q", 32'(reg_q), 32'b1110);
      tick();

      // nbits=0: straight from CHECK to DONE at E0+6.
      rnd_ready = 1'b1;
      start_run(4'b0101, 8'd0, 1'b0);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_valid", 32'(rnd_valid), 32'd0);
      chk("zero_q", 32'(reg_q), 32'b0101);
      tick();

      // Reset after two bits of an 8-bit run.
      start_run(4'b0001, 8'd8, 1'b0);
      tick();
      tick();
      chk("pre_rst_valid", 32'(rnd_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_sel", 32'(reg_sel), 32'd0);
      chk("mid_rst_sl", 32'(reg_sl_din), 32'd0);
      chk("mid_rst_valid", 32'(rnd_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_q", 32'(reg_q), 32'd0);
      chk("mid_rst_bit", 32'(rnd_bit), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_done", 32'(done), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
         tick();
      end
      // Start pulse during LOAD of the new run must not disturb it.
      run_full(4'b0001, 8'd4, 15'b0001_0000000_0000, 4'b1110, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
